// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
//   rx_state_e  : receive FSM states
//   DEFAULT_DIV : system clocks per bit at 133 MHz / 115200 baud
//   DATA_BITS   : payload bits per frame (8N1)
//   ptr_width() : FIFO pointer width for a given depth
package uart_pkg;

  localparam int unsigned DEFAULT_DIV = 1155;
  localparam int unsigned DATA_BITS   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i (ignored when full unless popping in the same cycle)
//   pop_i     : consume head entry (ignored when empty)
//   rdata_o   : head entry, valid while empty_o = 0
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
//   count_o   : occupancy 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [ptr_width(DEPTH):0]  count_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT receive FIFO.
//   clk, rst   : system clock, asynchronous active-high reset
//   uart_rx    : raw serial pad input, idle high, asynchronous to clk
//   rx_data    : FIFO head byte, valid while rx_valid = 1
//   rx_valid   : FIFO non-empty
//   rx_ready   : consumer takes the head byte this cycle
//   rx_count   : FIFO occupancy 0..DEPTH
//   frame_err  : one-cycle pulse when a stop bit samples low
//   overrun    : one-cycle pulse when a good byte is dropped because the FIFO is full
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV   = DEFAULT_DIV,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  output logic [DATA_BITS-1:0]     rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfLoad = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync_q, rxs;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 expiry;
  logic                 push, frame_err_d;
  logic                 frame_err_q, overrun_q;
  logic                 fifo_full, fifo_empty, pop;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rxs    <= sync_q;
    end
  end

  assign expiry = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!rxs) state_d = StStart;
      StStart:    if (expiry) state_d = rxs ? StIdle : StData;
      StData:     if (expiry && bit_idx_q == LastIdx) state_d = StStop;
      StStop:     if (expiry) state_d = rxs ? StIdle : StWaitHigh;
      StWaitHigh: if (rxs) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StStop: begin
        push        = expiry & rxs;
        frame_err_d = expiry & ~rxs;
      end
      default: ;
    endcase
  end

  // Baud counter, bit index and shift register. The half-bit load in IDLE puts
  // every later expiry in the middle of a bit cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        StIdle: if (!rxs) cnt_q <= HalfLoad;
        StStart: begin
          if (expiry) begin
            cnt_q     <= FullLoad;
            bit_idx_q <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (expiry) begin
            cnt_q     <= FullLoad;
            shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + IdxW'(1);
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: if (!expiry) cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

  assign pop = rx_valid & rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      // A coincident pop frees the slot, so only an unaccompanied push is dropped.
      overrun_q   <= push & fifo_full & ~pop;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_valid  = ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: counts error pulses and checks every popped byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0h expected none", rx_data);
        end else begin
          check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (rx_count != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", {31'h0, n < 100}, 32'h1);
    rx_ready = 1'b0;
    idle(2);
  endtask

  initial begin
    int f0, o0;
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_count", {29'h0, rx_count}, 32'h0);
    check("reset_data", {24'h0, rx_data}, 32'h0);
    check("reset_ferr", {31'h0, frame_err}, 32'h0);
    check("reset_ovr", {31'h0, overrun}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Good frame, consumer stalled.
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    check("a5_valid", {31'h0, rx_valid}, 32'h1);
    check("a5_data", {24'h0, rx_data}, 32'hA5);
    check("a5_count", {29'h0, rx_count}, 32'h1);
    check("a5_no_err", ferr_cnt + ovr_cnt, 32'h0);
    drain();

    // Quarter-bit glitch must be rejected as a false start.
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    check("glitch_count", {29'h0, rx_count}, 32'h0);
    check("glitch_ferr", ferr_cnt - f0, 32'h0);

    // Bad stop bit followed by a break, then a good frame.
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(logic'((8'h3C >> i) & 8'h1));
    uart_rx = 1'b0;
    idle(3 * DIV);
    uart_rx = 1'b1;
    idle(2 * DIV);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    check("break_ferr_once", ferr_cnt - f0, 32'h1);
    check("break_count", {29'h0, rx_count}, 32'h1);
    drain();

    // Five bytes into a four-entry FIFO.
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    check("full_count", {29'h0, rx_count}, 32'h4);
    check("full_overrun_once", ovr_cnt - o0, 32'h1);
    check("full_head", {24'h0, rx_data}, 32'h01);
    drain();

    // Full FIFO with a pop landing on the push cycle of the next byte.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h77);
    check("pre_swap_count", {29'h0, rx_count}, 32'h4);
    fork
      send_frame(8'h77, 1'b1);
      begin
        // Stop-bit sample lands 155 edges after the start bit is driven.
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("swap_count", {29'h0, rx_count}, 32'h4);
    check("swap_no_overrun", ovr_cnt - o0, 32'h0);
    drain();

    // Reset in the middle of a frame with two bytes buffered.
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    drive_bit(1'b0);
    uart_rx = 1'b1;
    idle(40);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, rx_valid}, 32'h0);
    check("midrst_count", {29'h0, rx_count}, 32'h0);
    check("midrst_data", {24'h0, rx_data}, 32'h0);
    exp_q.delete();
    idle(3);
    rst = 1'b0;
    idle(3 * DIV);
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    check("post_rst_count", {29'h0, rx_count}, 32'h1);
    check("post_rst_data", {24'h0, rx_data}, 32'h5A);
    drain();

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
